// File: rtl/toy_bus_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// toy_bus_sram_slave_pkg
//
// Shared definitions for the toy bus SRAM target:
//   - toy bus field widths and opcode encodings
//   - ToyBusReq / ToyBusAck field layouts
//   - FSM state encoding for the SRAM target
//   - toy_bus_make_ack(): builds the ack payload for an accepted request
//
// No ports (package).
// ---------------------------------------------------------------------------
package toy_bus_sram_slave_pkg;

    localparam int TOY_BUS_ADDR_W = 32;
    localparam int TOY_BUS_DATA_W = 32;
    localparam int TOY_BUS_STRB_W = 4;
    localparam int TOY_BUS_ID_W   = 4;

    localparam logic TOY_BUS_OP_RD = 1'b0;
    localparam logic TOY_BUS_OP_WR = 1'b1;

    // Read data returned for an out-of-range address when range checking is built in.
    localparam logic [TOY_BUS_DATA_W-1:0] TOY_BUS_OOR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [TOY_BUS_ADDR_W-1:0] addr;
        logic [TOY_BUS_STRB_W-1:0] strb;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic                      opcode;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_req_t;

    typedef struct packed {
        logic                      opcode;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;

    typedef enum logic [1:0] {
        SRAM_SLV_IDLE = 2'd0,
        SRAM_SLV_WAIT = 2'd1,
        SRAM_SLV_RESP = 2'd2
    } sram_slv_state_e;

    // The ack travels back towards the requester, so the id fields swap roles:
    // the ack source is this target and the ack destination is the requester.
    // Writes return zero data.
    function automatic toy_bus_ack_t toy_bus_make_ack(
        input logic                      opcode,
        input logic [TOY_BUS_ID_W-1:0]   req_src_id,
        input logic [TOY_BUS_ID_W-1:0]   req_tgt_id,
        input logic [TOY_BUS_DATA_W-1:0] rdata
    );
        toy_bus_ack_t ack;
        ack.opcode = opcode;
        ack.data   = (opcode == TOY_BUS_OP_RD) ? rdata : '0;
        ack.src_id = req_tgt_id;
        ack.tgt_id = req_src_id;
        return ack;
    endfunction

endpackage

// File: rtl/toy_bus_sram_slave_mem.sv
// ---------------------------------------------------------------------------
// toy_bus_sram_slave_mem
//
// DEPTH x 32-bit word array with a byte-enabled synchronous write port and an
// asynchronous read port. Contents are not reset.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write request for this cycle
//   wr_idx   in   word index written
//   wr_strb  in   byte enables (bit i covers data[8*i+7:8*i])
//   wr_data  in   write data
//   rd_idx   in   word index read
//   rd_data  out  word at rd_idx (combinational; shows pre-write contents
//                 in the cycle a write to the same word is presented)
// ---------------------------------------------------------------------------
module toy_bus_sram_slave_mem
    import toy_bus_sram_slave_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_idx,
    input  logic [TOY_BUS_STRB_W-1:0] wr_strb,
    input  logic [TOY_BUS_DATA_W-1:0] wr_data,
    input  logic [AW-1:0]             rd_idx,
    output logic [TOY_BUS_DATA_W-1:0] rd_data
);

    logic [TOY_BUS_DATA_W-1:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < TOY_BUS_STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem_array[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem_array[rd_idx];

endmodule

// File: rtl/toy_bus_sram_slave.sv
// ---------------------------------------------------------------------------
// toy_bus_sram_slave
//
// Terminal toy bus target. Accepts one request at a time, performs a word
// read or byte-enabled word write on an internal DEPTH x 32 memory, and
// returns exactly one ack per accepted request after WAIT_CYC wait states.
//
// Optional build macro TOY_BUS_SRAM_SLV_RANGE_CHK_EN:
//   defined   - addresses with bits above the word index set are out of
//               range: writes are dropped, reads return 32'hDEAD_BEEF, and
//               the ack is still returned with normal timing.
//   undefined - upper address bits are ignored (addresses alias modulo
//               DEPTH words).
//
// Parameters:
//   DEPTH     memory size in 32-bit words (power of two, >= 2)
//   WAIT_CYC  wait states between acceptance and ack (0..255)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in0_req_*          request channel (vld/rdy handshake)
//   in0_ack_*          ack channel (vld/rdy handshake)
// ---------------------------------------------------------------------------
module toy_bus_sram_slave
    import toy_bus_sram_slave_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      in0_req_vld,
    output logic                      in0_req_rdy,
    input  logic [TOY_BUS_ADDR_W-1:0] in0_req_addr,
    input  logic [TOY_BUS_STRB_W-1:0] in0_req_strb,
    input  logic [TOY_BUS_DATA_W-1:0] in0_req_data,
    input  logic                      in0_req_opcode,
    input  logic [TOY_BUS_ID_W-1:0]   in0_req_src_id,
    input  logic [TOY_BUS_ID_W-1:0]   in0_req_tgt_id,

    output logic                      in0_ack_vld,
    input  logic                      in0_ack_rdy,
    output logic                      in0_ack_opcode,
    output logic [TOY_BUS_DATA_W-1:0] in0_ack_data,
    output logic [TOY_BUS_ID_W-1:0]   in0_ack_src_id,
    output logic [TOY_BUS_ID_W-1:0]   in0_ack_tgt_id
);

    localparam int AW = $clog2(DEPTH);

    // The first wait cycle is the one right after acceptance, so the counter
    // starts one below WAIT_CYC and RESP is entered on the cycle it reads zero.
    localparam logic [7:0] WAIT_LOAD = (WAIT_CYC > 0) ? 8'(WAIT_CYC - 1) : 8'd0;

    sram_slv_state_e state, state_nxt;
    logic [7:0]      wait_cnt, wait_cnt_nxt;

    toy_bus_req_t              req;
    toy_bus_ack_t              ack_p1;
    logic                      accept;
    logic                      in_range;
    logic                      wr_en;
    logic [AW-1:0]             word_idx;
    logic [TOY_BUS_DATA_W-1:0] rd_word;
    logic [TOY_BUS_DATA_W-1:0] rd_data_eff;

    assign req = '{
        addr:   in0_req_addr,
        strb:   in0_req_strb,
        data:   in0_req_data,
        opcode: in0_req_opcode,
        src_id: in0_req_src_id,
        tgt_id: in0_req_tgt_id
    };

    assign word_idx = req.addr[AW+1:2];

`ifdef TOY_BUS_SRAM_SLV_RANGE_CHK_EN
    logic unused_addr_bits;
    assign in_range         = (req.addr[TOY_BUS_ADDR_W-1:AW+2] == '0);
    assign unused_addr_bits = ^req.addr[1:0];
`else
    logic unused_addr_bits;
    assign in_range         = 1'b1;
    assign unused_addr_bits = ^{req.addr[TOY_BUS_ADDR_W-1:AW+2], req.addr[1:0]};
`endif

    // Ready depends only on registered state and the downstream ready, so the
    // ack valid never has a combinational path from the request valid.
    assign in0_req_rdy = (state == SRAM_SLV_IDLE) ||
                         ((state == SRAM_SLV_RESP) && in0_ack_rdy);
    assign accept      = in0_req_vld && in0_req_rdy;

    assign wr_en       = accept && (req.opcode == TOY_BUS_OP_WR) && in_range;
    assign rd_data_eff = in_range ? rd_word : TOY_BUS_OOR_RDATA;

    toy_bus_sram_slave_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (word_idx),
        .wr_strb (req.strb),
        .wr_data (req.data),
        .rd_idx  (word_idx),
        .rd_data (rd_word)
    );

    // ---- control: state and wait counter -------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            SRAM_SLV_IDLE: begin
                if (accept) begin
                    if (WAIT_CYC > 0) begin
                        state_nxt    = SRAM_SLV_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt    = SRAM_SLV_RESP;
                    end
                end
            end
            SRAM_SLV_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_nxt    = SRAM_SLV_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 8'd1;
                end
            end
            SRAM_SLV_RESP: begin
                if (in0_ack_rdy) begin
                    // Ack retires this cycle; a new request may be taken in
                    // the same cycle for back-to-back operation.
                    if (accept) begin
                        if (WAIT_CYC > 0) begin
                            state_nxt    = SRAM_SLV_WAIT;
                            wait_cnt_nxt = WAIT_LOAD;
                        end else begin
                            state_nxt    = SRAM_SLV_RESP;
                        end
                    end else begin
                        state_nxt = SRAM_SLV_IDLE;
                    end
                end
            end
            default: begin
                state_nxt    = SRAM_SLV_IDLE;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SRAM_SLV_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ---- accept edge: ack payload captured -----------------------------
    // Read data is sampled from the asynchronous read port on the accept
    // edge, so the payload is fixed for the whole wait/response period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_p1 <= '0;
        end else if (accept) begin
            ack_p1 <= toy_bus_make_ack(req.opcode, req.src_id, req.tgt_id, rd_data_eff);
        end
    end

    // ---- ack outputs -----------------------------------------------------
    assign in0_ack_vld    = (state == SRAM_SLV_RESP);
    assign in0_ack_opcode = ack_p1.opcode;
    assign in0_ack_data   = ack_p1.data;
    assign in0_ack_src_id = ack_p1.src_id;
    assign in0_ack_tgt_id = ack_p1.tgt_id;

endmodule

// File: tb/tb_toy_bus_sram_slave.sv
module tb_toy_bus_sram_slave;

    localparam int   DEPTH  = 1024;
    localparam int   WAIT_B = 3;
    localparam logic OP_RD  = 1'b0;
    localparam logic OP_WR  = 1'b1;

    logic clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] req_vld, req_rdy, req_opcode;
    logic [1:0] ack_vld, ack_rdy, ack_opcode;
    logic [1:0][31:0] req_addr, req_data, ack_data;
    logic [1:0][3:0]  req_strb, req_src, req_tgt, ack_src, ack_tgt;

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    // Behavioural memory image per DUT (index 0: WAIT_CYC=0, index 1: WAIT_CYC=3).
    logic [31:0] ref_mem [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    toy_bus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .in0_req_vld(req_vld[0]), .in0_req_rdy(req_rdy[0]), .in0_req_addr(req_addr[0]),
        .in0_req_strb(req_strb[0]), .in0_req_data(req_data[0]), .in0_req_opcode(req_opcode[0]),
        .in0_req_src_id(req_src[0]), .in0_req_tgt_id(req_tgt[0]),
        .in0_ack_vld(ack_vld[0]), .in0_ack_rdy(ack_rdy[0]), .in0_ack_opcode(ack_opcode[0]),
        .in0_ack_data(ack_data[0]), .in0_ack_src_id(ack_src[0]), .in0_ack_tgt_id(ack_tgt[0])
    );

    toy_bus_sram_slave #(.DEPTH(DEPTH), .WAIT_CYC(WAIT_B)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .in0_req_vld(req_vld[1]), .in0_req_rdy(req_rdy[1]), .in0_req_addr(req_addr[1]),
        .in0_req_strb(req_strb[1]), .in0_req_data(req_data[1]), .in0_req_opcode(req_opcode[1]),
        .in0_req_src_id(req_src[1]), .in0_req_tgt_id(req_tgt[1]),
        .in0_ack_vld(ack_vld[1]), .in0_ack_rdy(ack_rdy[1]), .in0_ack_opcode(ack_opcode[1]),
        .in0_ack_data(ack_data[1]), .in0_ack_src_id(ack_src[1]), .in0_ack_tgt_id(ack_tgt[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input int d);
        int w;
        w = (d == 0) ? 0 : WAIT_B;
        return (w == 0) ? 1 : w + 1;
    endfunction

    function automatic bit ref_oor(input logic [31:0] a);
`ifdef TOY_BUS_SRAM_SLV_RANGE_CHK_EN
        return (a >> 2) >= 32'(DEPTH);
`else
        return 1'b0 && (a != a);
`endif
    endfunction

    // Applies one request to the memory image and returns the expected ack data.
    task automatic ref_access(input int d, input logic op, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] wd,
                              output logic [31:0] exp);
        int w;
        w = int'((a >> 2) % 32'(DEPTH));
        if (op == OP_WR) begin
            if (!ref_oor(a)) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) ref_mem[d][w][8*i +: 8] = wd[8*i +: 8];
                end
            end
            exp = 32'd0;
        end else if (ref_oor(a)) begin
            exp = 32'hDEAD_BEEF;
        end else begin
            exp = ref_mem[d][w];
        end
    endtask

    // Presents a request and returns (at #1 after the accepting edge) the cycle stamp.
    task automatic do_req(input int d, input logic op, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] wd,
                          input logic [3:0] src, input logic [3:0] tgt,
                          output int unsigned acc);
        int n;
        n = 0;
        req_opcode[d] = op;
        req_addr[d]   = a;
        req_strb[d]   = s;
        req_data[d]   = wd;
        req_src[d]    = src;
        req_tgt[d]    = tgt;
        req_vld[d]    = 1'b1;
        #1;
        while (req_rdy[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req_accepted_d%0d", d), {31'd0, req_rdy[d]}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_vld[d] = 1'b0;
    endtask

    // Waits (bounded) for the ack, checking ready stays low while busy; returns at
    // the falling edge on which the ack is visible.
    task automatic wait_ack(input int d, input logic op, input logic [31:0] exp,
                            input logic [3:0] exp_src, input logic [3:0] exp_tgt,
                            input int unsigned acc, output logic [31:0] got);
        int n;
        n = 0;
        @(negedge clk);
        while (ack_vld[d] !== 1'b1 && n < 300) begin
            check($sformatf("req_rdy_low_while_busy_d%0d", d), {31'd0, req_rdy[d]}, 32'd0);
            @(negedge clk);
            n++;
        end
        check($sformatf("ack_vld_d%0d", d), {31'd0, ack_vld[d]}, 32'd1);
        check($sformatf("ack_latency_d%0d", d), 32'(cyc + 1 - acc), 32'(exp_latency(d)));
        check($sformatf("ack_opcode_d%0d", d), {31'd0, ack_opcode[d]}, {31'd0, op});
        check($sformatf("ack_data_d%0d", d), ack_data[d], exp);
        check($sformatf("ack_src_d%0d", d), {28'd0, ack_src[d]}, {28'd0, exp_src});
        check($sformatf("ack_tgt_d%0d", d), {28'd0, ack_tgt[d]}, {28'd0, exp_tgt});
        got = ack_data[d];
    endtask

    task automatic txn(input int d, input logic op, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd,
                       input logic [3:0] src, input logic [3:0] tgt,
                       output logic [31:0] got, output int unsigned acc);
        logic [31:0] exp;
        do_req(d, op, a, s, wd, src, tgt, acc);
        ref_access(d, op, a, s, wd, exp);
        wait_ack(d, op, exp, tgt, src, acc, got);
    endtask

    function automatic logic [9:0] pool_idx(input int k);
        case (k)
            0:       return 10'd0;
            1:       return 10'd1;
            2:       return 10'd4;
            3:       return 10'd5;
            4:       return 10'd100;
            5:       return 10'd511;
            6:       return 10'd1022;
            default: return 10'd1023;
        endcase
    endfunction

    initial begin
        logic [31:0] got, exp1, exp2, a;
        logic [19:0] upper;
        logic        op;
        int unsigned acc, acc_prev, acc2;

        rst_n      = 2'b11;
        req_vld    = '0;
        req_opcode = '0;
        req_addr   = '0;
        req_strb   = '0;
        req_data   = '0;
        req_src    = '0;
        req_tgt    = '0;
        ack_rdy    = 2'b11;
        #1;
        rst_n = 2'b00;
        #10;

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ack_vld_d%0d", d), {31'd0, ack_vld[d]}, 32'd0);
            check($sformatf("rst_ack_opcode_d%0d", d), {31'd0, ack_opcode[d]}, 32'd0);
            check($sformatf("rst_ack_data_d%0d", d), ack_data[d], 32'd0);
            check($sformatf("rst_ack_src_d%0d", d), {28'd0, ack_src[d]}, 32'd0);
            check($sformatf("rst_ack_tgt_d%0d", d), {28'd0, ack_tgt[d]}, 32'd0);
            check($sformatf("rst_req_rdy_d%0d", d), {31'd0, req_rdy[d]}, 32'd1);
        end
        @(negedge clk);
        rst_n = 2'b11;
        @(posedge clk);
        #1;

        // 1: write then read, WAIT_CYC=0.
        txn(0, OP_WR, 32'h10, 4'hF, 32'hA5A5_1234, 4'd3, 4'd7, got, acc);
        check("t1_write_ack_data", got, 32'd0);
        txn(0, OP_RD, 32'h10, 4'h0, 32'h0, 4'd3, 4'd7, got, acc);
        check("t1_read_data", got, 32'hA5A5_1234);

        // 2: partial write.
        txn(0, OP_WR, 32'h14, 4'hF, 32'hFFFF_FFFF, 4'd1, 4'd2, got, acc);
        txn(0, OP_WR, 32'h14, 4'b0101, 32'h0000_0000, 4'd1, 4'd2, got, acc);
        txn(0, OP_WR, 32'h14, 4'b0000, 32'h1234_5678, 4'd1, 4'd2, got, acc);
        txn(0, OP_RD, 32'h14, 4'h0, 32'h0, 4'd1, 4'd2, got, acc);
        check("t2_partial_write", got, 32'hFF00_FF00);

        // 3: WAIT_CYC=3 back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            txn(1, OP_WR, 32'h40 + 32'(4 * i), 4'hF, 32'h5000_0000 + 32'(i), 4'd2, 4'd9, got, acc);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1, OP_RD, 32'h40 + 32'(4 * i), 4'h0, 32'h0, 4'd5, 4'd9, got, acc);
            check("t3_read_data", got, 32'h5000_0000 + 32'(i));
            if (i > 0) check("t3_accept_spacing", 32'(acc - acc_prev), 32'(WAIT_B + 1));
            acc_prev = acc;
        end

        // 4: ack backpressure on the WAIT_CYC=0 instance.
        @(posedge clk);
        #1;
        ack_rdy[0] = 1'b0;
        do_req(0, OP_RD, 32'h10, 4'h0, 32'h0, 4'd4, 4'd6, acc);
        ref_access(0, OP_RD, 32'h10, 4'h0, 32'h0, exp1);
        req_opcode[0] = OP_RD;
        req_addr[0]   = 32'h14;
        req_src[0]    = 4'd8;
        req_tgt[0]    = 4'd6;
        req_vld[0]    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_ack_vld", {31'd0, ack_vld[0]}, 32'd1);
            check("t4_hold_ack_data", ack_data[0], exp1);
            check("t4_hold_ack_tgt", {28'd0, ack_tgt[0]}, 32'd4);
            check("t4_hold_req_rdy", {31'd0, req_rdy[0]}, 32'd0);
        end
        ack_rdy[0] = 1'b1;
        #1;
        check("t4_release_req_rdy", {31'd0, req_rdy[0]}, 32'd1);
        @(posedge clk);
        #1;
        acc2 = cyc;
        req_vld[0] = 1'b0;
        check("t4_same_cycle_accept", 32'(acc2 - acc), 32'd5);
        ref_access(0, OP_RD, 32'h14, 4'h0, 32'h0, exp2);
        wait_ack(0, OP_RD, exp2, 4'd6, 4'd8, acc2, got);
        check("t4_second_read", got, 32'hFF00_FF00);

        // 5: reset while in WAIT after a write.
        @(posedge clk);
        #1;
        do_req(1, OP_WR, 32'h20, 4'hF, 32'h1, 4'd1, 4'd3, acc);
        ref_access(1, OP_WR, 32'h20, 4'hF, 32'h1, exp1);
        #2;
        rst_n[1] = 1'b0;
        #1;
        check("t5_rst_ack_vld", {31'd0, ack_vld[1]}, 32'd0);
        check("t5_rst_ack_data", ack_data[1], 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_ack_after_reset", {31'd0, ack_vld[1]}, 32'd0);
        end
        @(posedge clk);
        #1;
        txn(1, OP_RD, 32'h20, 4'h0, 32'h0, 4'd1, 4'd3, got, acc);
        check("t5_write_committed", got, 32'h1);

        // 6: aliasing / range check.
        txn(0, OP_WR, 32'h0, 4'hF, 32'h1111_2222, 4'd1, 4'd2, got, acc);
        txn(0, OP_WR, 32'h1000, 4'hF, 32'hCAFE_0001, 4'd1, 4'd2, got, acc);
        txn(0, OP_RD, 32'h0, 4'h0, 32'h0, 4'd1, 4'd2, got, acc);
`ifdef TOY_BUS_SRAM_SLV_RANGE_CHK_EN
        check("t6_word0_unchanged", got, 32'h1111_2222);
`else
        check("t6_alias_read", got, 32'hCAFE_0001);
`endif
        txn(0, OP_RD, 32'h1000, 4'h0, 32'h0, 4'd1, 4'd2, got, acc);
`ifdef TOY_BUS_SRAM_SLV_RANGE_CHK_EN
        check("t6_oor_read", got, 32'hDEAD_BEEF);
`else
        check("t6_alias_read_hi", got, 32'hCAFE_0001);
`endif

        // Randomised traffic on both instances against the memory image.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                a = {20'd0, pool_idx(k), 2'b00};
                txn(d, OP_WR, a, 4'hF, $urandom, 4'($urandom), 4'($urandom), got, acc);
            end
            for (int n = 0; n < 30; n++) begin
                upper = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0;
                a     = {upper, pool_idx(int'($urandom_range(0, 7))), 2'($urandom)};
                op    = 1'($urandom);
                txn(d, op, a, 4'($urandom), $urandom, 4'($urandom), 4'($urandom), got, acc);
            end
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
